// File: rtl/crypto_seq_ctrl_pkg.sv
// Shared encodings for the crypto-extension sequencer: instruction classes,
// sequencer state codes and the detector's mode words.
package crypto_seq_ctrl_pkg;

    typedef logic [1:0] crypt_class_t;

    localparam crypt_class_t CRYPT_CLASS_AES    = 2'd0;
    localparam crypt_class_t CRYPT_CLASS_SHA256 = 2'd1;
    localparam crypt_class_t CRYPT_CLASS_SHA512 = 2'd2;
    localparam crypt_class_t CRYPT_CLASS_EXT    = 2'd3;

    localparam logic [1:0] CSEQ_IDLE = 2'd0;
    localparam logic [1:0] CSEQ_BUSY = 2'd1;
    localparam logic [1:0] CSEQ_WB   = 2'd2;

    localparam int unsigned CRYPT_MODE_W = 21;

    localparam logic [CRYPT_MODE_W-1:0] CRYPT_MODE_AES32ESI   = 21'h00_0011;
    localparam logic [CRYPT_MODE_W-1:0] CRYPT_MODE_AES32DSMI  = 21'h00_0024;
    localparam logic [CRYPT_MODE_W-1:0] CRYPT_MODE_SHA256SIG0 = 21'h01_0102;
    localparam logic [CRYPT_MODE_W-1:0] CRYPT_MODE_SHA512SUM1 = 21'h02_0208;
    localparam logic [CRYPT_MODE_W-1:0] CRYPT_MODE_EXT_CUSTOM = 21'h1F_A5C3;

    function automatic logic is_ext_class(input crypt_class_t cls);
        return cls == CRYPT_CLASS_EXT;
    endfunction

endpackage

// File: rtl/crypto_seq_ctrl_if.sv
// Bundle between the crypto detector / execution unit (master side) and the
// crypto sequencer (slave side).
interface crypto_seq_ctrl_if #(
    parameter int unsigned MODE_W = 21,
    parameter int unsigned CNT_W  = 16
);
    logic              crypt_instr;
    logic [1:0]        crypt_class;
    logic [MODE_W-1:0] crypt_mode_in;
    logic              cu_done;

    logic              select_comb_ctrls;
    logic              hold;
    logic              regWrite;
    logic              cu_start;
    logic [MODE_W-1:0] cu_mode;
    logic              busy;
    logic              err_timeout;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output crypt_instr, crypt_class, crypt_mode_in, cu_done,
        input  select_comb_ctrls, hold, regWrite, cu_start, cu_mode, busy, err_timeout,
               op_count
    );

    modport slave (
        input  crypt_instr, crypt_class, crypt_mode_in, cu_done,
        output select_comb_ctrls, hold, regWrite, cu_start, cu_mode, busy, err_timeout,
               op_count
    );

endinterface

// File: rtl/crypto_lat_table.sv
// Class -> hold-cycle latency lookup for the fixed-latency crypto classes.
module crypto_lat_table
    import crypto_seq_ctrl_pkg::*;
#(
    parameter int unsigned LAT_AES    = 1,
    parameter int unsigned LAT_SHA256 = 1,
    parameter int unsigned LAT_SHA512 = 2
) (
    input  crypt_class_t i_class,
    output logic [3:0]   o_lat
);

    always_comb begin
        o_lat = 4'd1;
        case (i_class)
            CRYPT_CLASS_AES:    o_lat = 4'(LAT_AES);
            CRYPT_CLASS_SHA256: o_lat = 4'(LAT_SHA256);
            CRYPT_CLASS_SHA512: o_lat = 4'(LAT_SHA512);
            // EXT is done-driven; its latency is never consulted
            default:            o_lat = 4'd1;
        endcase
    end

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Multi-cycle sequencer for crypto-extension instructions: stalls the PC for a
// per-class latency (or until the unit reports done), then issues one writeback.
module crypto_seq_ctrl
    import crypto_seq_ctrl_pkg::*;
#(
    parameter int unsigned MODE_W      = 21,
    parameter int unsigned LAT_AES     = 1,
    parameter int unsigned LAT_SHA256  = 1,
    parameter int unsigned LAT_SHA512  = 2,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    crypto_seq_ctrl_if.slave bus
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    logic [1:0]        r_state, w_state_d;
    crypt_class_t      r_class, w_class_d;
    logic [7:0]        r_lat_cnt, w_lat_cnt_d;
    logic              r_abort, w_abort_d;
    logic [MODE_W-1:0] r_cu_mode, w_cu_mode_d;
    logic [CNT_W-1:0]  r_op_count, w_op_count_d;

    logic [3:0] w_lat;
    logic       w_hold;
    logic       w_select;
    logic       w_reg_write;
    logic       w_cu_start;
    logic       w_err_timeout;

    crypto_lat_table #(
        .LAT_AES    (LAT_AES),
        .LAT_SHA256 (LAT_SHA256),
        .LAT_SHA512 (LAT_SHA512)
    ) u_lat_table (
        .i_class (bus.crypt_class),
        .o_lat   (w_lat)
    );

    always_comb begin
        w_state_d     = r_state;
        w_class_d     = r_class;
        w_lat_cnt_d   = r_lat_cnt;
        w_abort_d     = r_abort;
        w_cu_mode_d   = r_cu_mode;
        w_op_count_d  = r_op_count;
        w_hold        = 1'b0;
        w_select      = 1'b1;
        w_reg_write   = 1'b0;
        w_cu_start    = 1'b0;
        w_err_timeout = 1'b0;

        case (r_state)
            CSEQ_IDLE: begin
                if (bus.crypt_instr) begin
                    w_hold      = 1'b1;
                    w_select    = 1'b0;
                    w_cu_start  = 1'b1;
                    w_cu_mode_d = bus.crypt_mode_in;
                    w_class_d   = bus.crypt_class;
                    w_abort_d   = 1'b0;
                    if (is_ext_class(bus.crypt_class)) begin
                        w_lat_cnt_d = 8'd0;
                        w_state_d   = CSEQ_BUSY;
                    end else if (w_lat == 4'd1) begin
                        w_state_d = CSEQ_WB;
                    end else begin
                        // The issue cycle already counts as one hold cycle
                        w_lat_cnt_d = 8'(w_lat) - 8'd2;
                        w_state_d   = CSEQ_BUSY;
                    end
                end
            end

            CSEQ_BUSY: begin
                w_hold   = 1'b1;
                w_select = 1'b0;
                if (is_ext_class(r_class)) begin
                    if (bus.cu_done) begin
                        w_state_d = CSEQ_WB;
                    end else if (r_lat_cnt == TimeoutLast) begin
                        w_abort_d = 1'b1;
                        w_state_d = CSEQ_WB;
                    end else begin
                        w_lat_cnt_d = r_lat_cnt + 8'd1;
                    end
                end else if (r_lat_cnt == 8'd0) begin
                    w_state_d = CSEQ_WB;
                end else begin
                    w_lat_cnt_d = r_lat_cnt - 8'd1;
                end
            end

            CSEQ_WB: begin
                // The instruction is still on the bus here, so never re-issue from WB
                w_select      = 1'b0;
                w_reg_write   = ~r_abort;
                w_err_timeout = r_abort;
                if (!r_abort) begin
                    w_op_count_d = r_op_count + CNT_W'(1);
                end
                w_state_d = CSEQ_IDLE;
            end

            default: w_state_d = CSEQ_IDLE;
        endcase

        // Async reset already forces IDLE; this also masks the Mealy issue path
        if (!rst_n) begin
            w_hold        = 1'b0;
            w_select      = 1'b1;
            w_reg_write   = 1'b0;
            w_cu_start    = 1'b0;
            w_err_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CSEQ_IDLE;
            r_class    <= CRYPT_CLASS_AES;
            r_lat_cnt  <= '0;
            r_abort    <= 1'b0;
            r_cu_mode  <= '0;
            r_op_count <= '0;
        end else begin
            r_state    <= w_state_d;
            r_class    <= w_class_d;
            r_lat_cnt  <= w_lat_cnt_d;
            r_abort    <= w_abort_d;
            r_cu_mode  <= w_cu_mode_d;
            r_op_count <= w_op_count_d;
        end
    end

    assign bus.select_comb_ctrls = w_select;
    assign bus.hold              = w_hold;
    assign bus.regWrite          = w_reg_write;
    assign bus.cu_start          = w_cu_start;
    assign bus.cu_mode           = r_cu_mode;
    assign bus.busy              = (r_state != CSEQ_IDLE);
    assign bus.err_timeout       = w_err_timeout;
    assign bus.op_count          = r_op_count;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Scoreboard bench for crypto_seq_ctrl: an op-level model pushes per-cycle and
// per-writeback expectations; an independent monitor pops and compares.
module tb_crypto_seq_ctrl;
    import crypto_seq_ctrl_pkg::*;

    localparam int unsigned MODE_W      = 21;
    localparam int unsigned LAT_AES     = 1;
    localparam int unsigned LAT_SHA256  = 3;
    localparam int unsigned LAT_SHA512  = 2;
    localparam int unsigned TIMEOUT_CYC = 6;
    localparam int unsigned CNT_W       = 3;

    typedef struct packed {
        logic              hold;
        logic              sel;
        logic              rw;
        logic              start;
        logic              err;
        logic              busy;
        logic [MODE_W-1:0] mode;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic              normal;
        logic [MODE_W-1:0] mode;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crypto_seq_ctrl_if #(.MODE_W(MODE_W), .CNT_W(CNT_W)) bus ();

    crypto_seq_ctrl #(
        .MODE_W      (MODE_W),
        .LAT_AES     (LAT_AES),
        .LAT_SHA256  (LAT_SHA256),
        .LAT_SHA512  (LAT_SHA512),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    wb_t  wb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    // Model state: last latched mode and completed-op count
    logic [MODE_W-1:0] m_mode;
    logic [CNT_W-1:0]  m_cnt;

    function automatic int lat_of(input logic [1:0] cls);
        case (cls)
            CRYPT_CLASS_AES:    return LAT_AES;
            CRYPT_CLASS_SHA256: return LAT_SHA256;
            default:            return LAT_SHA512;
        endcase
    endfunction

    function automatic exp_t quiet_exp(input logic [MODE_W-1:0] mode, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e      = '0;
        e.sel  = 1'b1;
        e.mode = mode;
        e.cnt  = cnt;
        return e;
    endfunction

    task automatic step(input logic rst, input logic instr, input logic [1:0] cls,
                        input logic [MODE_W-1:0] mode, input logic done, input exp_t e);
        rst_n             = rst;
        bus.crypt_instr   = instr;
        bus.crypt_class   = cls;
        bus.crypt_mode_in = mode;
        bus.cu_done       = done;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 2'($urandom_range(0, 3)), MODE_W'($urandom()),
                 1'($urandom_range(0, 1)), quiet_exp(m_mode, m_cnt));
    endtask

    task automatic do_reset(input int n);
        m_mode = '0;
        m_cnt  = '0;
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), MODE_W'($urandom()),
                 1'($urandom_range(0, 1)), quiet_exp('0, '0));
    endtask

    // d: cycle after issue at which cu_done pulses for EXT; outside 1..TIMEOUT_CYC means never
    task automatic do_op(input logic [1:0] cls, input logic [MODE_W-1:0] mode, input int d);
        int   h;
        bit   normal;
        bit   ext;
        logic done;
        exp_t e;
        ext = (cls == CRYPT_CLASS_EXT);
        if (ext) begin
            normal = (d >= 1 && d <= int'(TIMEOUT_CYC));
            h      = normal ? d + 1 : int'(TIMEOUT_CYC) + 1;
        end else begin
            normal = 1'b1;
            h      = lat_of(cls);
        end
        wb_q.push_back('{normal: normal, mode: mode});
        for (int c = 0; c <= h; c++) begin
            e      = '0;
            e.cnt  = m_cnt;
            e.mode = (c == 0) ? m_mode : mode;
            if (c < h) begin
                e.hold  = 1'b1;
                e.start = (c == 0);
                e.busy  = (c != 0);
            end else begin
                e.rw   = normal;
                e.err  = !normal;
                e.busy = 1'b1;
            end
            if (ext && c >= 1 && c < h) done = (c == d);
            else done = 1'($urandom_range(0, 1));
            if (c == 0) step(1'b1, 1'b1, cls, mode, done, e);
            else step(1'b1, 1'b1, 2'($urandom_range(0, 3)), MODE_W'($urandom()), done, e);
        end
        m_mode = mode;
        if (normal) m_cnt = m_cnt + CNT_W'(1);
    endtask

    initial begin : driver
        exp_t e;
        logic [1:0] cls;
        m_mode = '0;
        m_cnt  = '0;
        do_reset(2);
        idle(2);

        do_op(CRYPT_CLASS_AES, CRYPT_MODE_AES32ESI, 0);
        idle(1);
        do_op(CRYPT_CLASS_SHA512, CRYPT_MODE_SHA512SUM1, 0);
        idle(1);
        do_op(CRYPT_CLASS_EXT, CRYPT_MODE_EXT_CUSTOM, 5);
        idle(2);
        do_op(CRYPT_CLASS_EXT, CRYPT_MODE_AES32DSMI, 0);
        idle(1);
        do_op(CRYPT_CLASS_EXT, CRYPT_MODE_SHA256SIG0, TIMEOUT_CYC);
        idle(1);
        do_op(CRYPT_CLASS_SHA256, CRYPT_MODE_SHA256SIG0, 0);
        do_op(CRYPT_CLASS_AES, CRYPT_MODE_AES32DSMI, 0);
        idle(2);

        // Reset during the BUSY cycle of a SHA512 op: no writeback, no error
        e       = '0;
        e.hold  = 1'b1;
        e.start = 1'b1;
        e.mode  = m_mode;
        e.cnt   = m_cnt;
        step(1'b1, 1'b1, CRYPT_CLASS_SHA512, CRYPT_MODE_SHA512SUM1, 1'b0, e);
        do_reset(2);
        idle(4);

        for (int n = 0; n < 5; n++) do_op(CRYPT_CLASS_AES, MODE_W'($urandom()), 0);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            cls = 2'($urandom_range(0, 3));
            do_op(cls, MODE_W'($urandom()), $urandom_range(0, TIMEOUT_CYC + 1));
            idle($urandom_range(0, 2));
        end
        idle(3);

        #5;
        n_checks++;
        if (wb_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_writebacks: %0d writebacks never seen, required 0", wb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : monitor
        exp_t e;
        exp_t a;
        wb_t  w;
        forever begin
            #3;
            a.hold  = bus.hold;
            a.sel   = bus.select_comb_ctrls;
            a.rw    = bus.regWrite;
            a.start = bus.cu_start;
            a.err   = bus.err_timeout;
            a.busy  = bus.busy;
            a.mode  = bus.cu_mode;
            a.cnt   = bus.op_count;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs cycle %0d: got hold=%b sel=%b rw=%b start=%b err=%b busy=%b mode=%h cnt=%0d, required hold=%b sel=%b rw=%b start=%b err=%b busy=%b mode=%h cnt=%0d",
                             cyc, a.hold, a.sel, a.rw, a.start, a.err, a.busy, a.mode, a.cnt,
                             e.hold, e.sel, e.rw, e.start, e.err, e.busy, e.mode, e.cnt);
                end
            end
            if (bus.regWrite === 1'b1 || bus.err_timeout === 1'b1) begin
                n_checks++;
                if (wb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL writeback cycle %0d: got rw=%b err=%b, required no writeback",
                             cyc, bus.regWrite, bus.err_timeout);
                end else begin
                    w = wb_q.pop_front();
                    if (bus.regWrite !== w.normal || bus.err_timeout !== !w.normal ||
                        bus.cu_mode !== w.mode) begin
                        n_err++;
                        $display("FAIL writeback cycle %0d: got rw=%b err=%b mode=%h, required rw=%b err=%b mode=%h",
                                 cyc, bus.regWrite, bus.err_timeout, bus.cu_mode,
                                 w.normal, !w.normal, w.mode);
                    end
                end
            end
            cyc++;
            @(negedge clk);
        end
    end

endmodule

// File: doc/crypto_seq_ctrl.md
Name: crypto_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for crypto-extension instructions.
- Sits between the crypto instruction detector, the main combinational control and the crypto execution unit.
- Stalls the PC for a per-class latency, or until the unit reports done, then issues one register writeback.
- Reports timeouts and counts completed operations.

Parameters:
- MODE_W, 21, width of crypto mode word from detector.
- LAT_AES, 1, hold cycles for AES class (range 1..15).
- LAT_SHA256, 1, hold cycles for SHA256 class (range 1..15).
- LAT_SHA512, 2, hold cycles for SHA512 class (range 1..15).
- TIMEOUT_CYC, 16, maximum BUSY cycles for EXT class before abort (range 2..255).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- crypt_instr  in  1  current decoded instruction is a crypto op
- crypt_class  in  2  0 AES, 1 SHA256, 2 SHA512, 3 EXT (done-driven)
- crypt_mode_in  in  MODE_W  mode word from detector
- cu_done  in  1  crypto unit result ready (EXT class only)
- select_comb_ctrls  out  1  1: main control drives regWrite/pcSrc/wdSrc/dmWe; 0: crypto overrides
- hold  out  1  stall PC
- regWrite  out  1  crypto-result register write enable
- cu_start  out  1  one-cycle start pulse to crypto unit
- cu_mode  out  MODE_W  latched mode for the crypto unit
- busy  out  1  state != IDLE
- err_timeout  out  1  one-cycle pulse on EXT abort
- op_count  out  CNT_W  completed (written-back) crypto ops, wraps

Behaviour:
- Reset: async to IDLE; cu_mode, lat_cnt and op_count = 0; err_timeout = 0. While rst_n = 0, combinational outputs are forced: hold = 0, select_comb_ctrls = 1, regWrite = 0, cu_start = 0.
- States: IDLE, BUSY, WB. The encoding is a shared constant.
- Latency L(class) = LAT_AES, LAT_SHA256 or LAT_SHA512. L counts hold cycles including the issue cycle.
- IDLE, crypt_instr = 0:
  - select = 1, hold = 0, outputs pass through.
- IDLE, crypt_instr = 1 (Mealy, same cycle):
  - hold = 1, select = 0, cu_start = 1, regWrite = 0.
  - Latch cu_mode <= crypt_mode_in and class.
  - Fixed class with L = 1: next WB.
  - Fixed class with L > 1: lat_cnt <= L-2, next BUSY.
  - EXT: lat_cnt <= 0, next BUSY.
- BUSY (hold = 1, select = 0, cu_start = 0):
  - Fixed class: if lat_cnt == 0, next WB; else decrement.
  - EXT: if cu_done, next WB. Else if lat_cnt == TIMEOUT_CYC-1, next WB with abort flag. Else increment.
  - cu_done takes priority over timeout in the same cycle.
- WB (hold = 0, select = 0, lasts exactly 1 cycle):
  - Normal completion: regWrite = 1, op_count += 1 (wraps at 2^CNT_W).
  - Abort: regWrite = 0, err_timeout = 1, op_count unchanged.
  - Next IDLE unconditionally; crypt_instr in WB is ignored because the same instruction is still on the bus.
  - Downstream, the crypto override selects pcSrc = PC+4 and wdSrc = crypto.
- Total cycles per fixed-class op = L + 1. L = 1 reproduces the two-cycle legacy sequence.
- cu_done in IDLE, WB, or BUSY with a fixed class: ignored.
- crypt_class / crypt_mode_in changes after issue: ignored, since latched values are used.
- Reset mid-op: immediate return to IDLE with no writeback and no error pulse.
- cu_mode holds its last value in IDLE.

Decomposition:
- Shared header gains:
  - CRYPT_CLASS_AES/SHA256/SHA512/EXT codes.
  - State encodings CSEQ_IDLE/BUSY/WB.
  - CRYPT_MODE_* mode words.
- One natural sub-module, crypto_lat_table: combinational class -> L lookup, parametrised by the LAT_* parameters.
- Counter and FSM stay in crypto_seq_ctrl.

Test Plan:
- AES with LAT_AES = 1: pulse crypt_instr for 1 cycle, then hold the instruction stable.
  - Expect hold = 1 in cycle 0; WB in cycle 1 with regWrite = 1 and hold = 0; IDLE in cycle 2; op_count = 1.
- SHA512 with LAT_SHA512 = 2:
  - Expect hold for 2 cycles, regWrite in cycle 2, and exactly one cu_start pulse in cycle 0.
  - Assert cu_done mid-op: no effect.
- EXT class, cu_done asserted 5 cycles after issue:
  - Expect hold for 6 cycles total, WB with regWrite = 1 on the following cycle, cu_mode equal to the issued value throughout.
- EXT class, TIMEOUT_CYC = 4, cu_done never asserted:
  - Expect BUSY for 4 cycles, then WB with regWrite = 0 and err_timeout = 1, and op_count unchanged.
  - Variant: cu_done and timeout coincide → normal completion.
- Back-to-back: SHA256 followed immediately by AES.
  - Expect the WB cycle not to retrigger; second issue in the cycle after WB; op_count = 2.
- Reset mid-op: drop rst_n in BUSY of a SHA512 op.
  - Expect IDLE, hold = 0, select = 1, op_count = 0, and no regWrite or err_timeout pulses after release.
- op_count wrap with CNT_W = 2: 5 ops → op_count = 1.
